// File: rtl/tracker_pkg.sv
// tracker_pkg: constants and types shared by the tracker front end.
//   - Default 640x480 video timing (800x525 total) and object size.
//   - RGB888 colour constants for object, background, grid and blanking.
//   - svs_state_t: synthetic video source run-control states.
//   - axis_step(): one frame of bounce motion along one axis.
package tracker_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_OBJ_SIZE = 32;

  localparam logic [23:0] COLOR_OBJ   = 24'hFFFFFF;
  localparam logic [23:0] COLOR_BG    = 24'h202020;
  localparam logic [23:0] COLOR_GRID  = 24'h303030;
  localparam logic [23:0] COLOR_BLANK = 24'h000000;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StStopPend = 2'd2
  } svs_state_t;

  typedef struct packed {
    logic [15:0] pos;
    logic        dir;  // 1: increasing
  } obj_axis_t;

  // 17-bit arithmetic so pos+step can exceed the 16-bit range without wrapping.
  function automatic obj_axis_t axis_step(input logic [15:0] pos, input logic dir,
                                          input logic [3:0] step, input logic [16:0] max_pos);
    obj_axis_t   r;
    logic [16:0] fwd;
    fwd   = {1'b0, pos} + {13'd0, step};
    r.pos = pos;
    r.dir = dir;
    if (dir) begin
      if (fwd > max_pos) begin
        r.pos = max_pos[15:0];
        r.dir = 1'b0;
      end else begin
        r.pos = fwd[15:0];
      end
    end else begin
      if ({13'd0, step} > {1'b0, pos}) begin
        r.pos = 16'd0;
        r.dir = 1'b1;
      end else begin
        r.pos = pos - {12'd0, step};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// video_timing_counter: horizontal/vertical pixel counters and region decode.
//   clk_i       pixel clock
//   rst_ni      asynchronous active-low reset
//   run_i       count enable; counters are cleared to 0 while low
//   h_cnt_o     pixel index within the line
//   v_cnt_o     line index within the frame
//   active_o    counters are inside the active area
//   h_sync_o    unregistered horizontal sync decode
//   v_sync_o    unregistered vertical sync decode
//   frame_end_o last cycle of the frame while running
module video_timing_counter
  import tracker_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  output logic [15:0] h_cnt_o,
  output logic [15:0] v_cnt_o,
  output logic        active_o,
  output logic        h_sync_o,
  output logic        v_sync_o,
  output logic        frame_end_o
);

  localparam logic [15:0] HLast    = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] VLast    = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] HAct     = 16'(H_ACTIVE);
  localparam logic [15:0] VAct     = 16'(V_ACTIVE);
  localparam logic [15:0] HsStart  = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HsEnd    = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VsStart  = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VsEnd    = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        line_end;

  always_comb begin
    line_end    = (h_cnt_q == HLast);
    frame_end_o = run_i && line_end && (v_cnt_q == VLast);
    h_cnt_d     = h_cnt_q + 16'd1;
    v_cnt_d     = v_cnt_q;
    if (!run_i) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (line_end) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VLast) ? 16'd0 : v_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    active_o = (h_cnt_q < HAct) && (v_cnt_q < VAct);
    h_sync_o = (h_cnt_q >= HsStart) && (h_cnt_q < HsEnd);
    v_sync_o = (v_cnt_q >= VsStart) && (v_cnt_q < VsEnd);
  end

  assign h_cnt_o = h_cnt_q;
  assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/synthetic_video_source.sv
// synthetic_video_source: video timing generator with a bouncing white square on a dark
// background, used in place of a camera so bounding-box results are known exactly.
//   clk          pixel clock
//   rst          asynchronous active-low reset
//   enable       run request, honoured at frame boundaries
//   obj_step     object motion per frame on both axes (sampled on the frame-end cycle)
//   h_sync       active-high horizontal sync
//   v_sync       active-high vertical sync
//   de           active-area data enable
//   pixel_out    RGB888 pixel
//   x_pos/y_pos  coordinates of pixel_out, 0 outside the active area
//   frame_start  one-cycle pulse with pixel (0,0)
// All outputs are registered, one cycle behind the counters.
// Optional build macro SVS_GRID_EN: draws a 64-pixel grid in the background.
module synthetic_video_source
  import tracker_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned OBJ_SIZE = DEF_OBJ_SIZE  // must be below H_ACTIVE and V_ACTIVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  obj_step,
  output logic        h_sync,
  output logic        v_sync,
  output logic        de,
  output logic [23:0] pixel_out,
  output logic [15:0] x_pos,
  output logic [15:0] y_pos,
  output logic        frame_start
);

  localparam logic [16:0] XMax   = 17'(H_ACTIVE - OBJ_SIZE);
  localparam logic [16:0] YMax   = 17'(V_ACTIVE - OBJ_SIZE);
  localparam logic [16:0] ObjExt = 17'(OBJ_SIZE);

  svs_state_t  state_q, state_d;
  logic        run;
  logic [15:0] h_cnt, v_cnt;
  logic        active, hs_c, vs_c, frame_end;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i       (clk),
    .rst_ni      (rst),
    .run_i       (run),
    .h_cnt_o     (h_cnt),
    .v_cnt_o     (v_cnt),
    .active_o    (active),
    .h_sync_o    (hs_c),
    .v_sync_o    (vs_c),
    .frame_end_o (frame_end)
  );

  assign run = (state_q != StIdle);

  // Stopping only takes effect at frame end so a partial frame is never emitted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (enable) state_d = StRun;
      StRun:      if (!enable) state_d = frame_end ? StIdle : StStopPend;
      StStopPend: begin
        if (enable)         state_d = StRun;
        else if (frame_end) state_d = StIdle;
      end
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Object position: updated once per frame on the frame-end cycle.
  logic [15:0] obj_x_q, obj_y_q;
  logic        dir_x_q, dir_y_q;
  obj_axis_t   nx, ny;

  always_comb begin
    nx = axis_step(obj_x_q, dir_x_q, obj_step, XMax);
    ny = axis_step(obj_y_q, dir_y_q, obj_step, YMax);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      obj_x_q <= '0;
      obj_y_q <= '0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
    end else if (frame_end) begin
      obj_x_q <= nx.pos;
      obj_y_q <= ny.pos;
      dir_x_q <= nx.dir;
      dir_y_q <= ny.dir;
    end
  end

  // Pixel mux
  logic        in_obj;
  logic [23:0] bg, pix_d;

  always_comb begin
    in_obj = ({1'b0, h_cnt} >= {1'b0, obj_x_q}) && ({1'b0, h_cnt} < {1'b0, obj_x_q} + ObjExt) &&
             ({1'b0, v_cnt} >= {1'b0, obj_y_q}) && ({1'b0, v_cnt} < {1'b0, obj_y_q} + ObjExt);
`ifdef SVS_GRID_EN
    bg = ((h_cnt[5:0] == 6'd0) || (v_cnt[5:0] == 6'd0)) ? COLOR_GRID : COLOR_BG;
`else
    bg = COLOR_BG;
`endif
    if (!active)     pix_d = COLOR_BLANK;
    else if (in_obj) pix_d = COLOR_OBJ;
    else             pix_d = bg;
  end

  // Output registers; counters sit at (0,0) in idle, so every output is gated by run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_sync      <= 1'b0;
      v_sync      <= 1'b0;
      de          <= 1'b0;
      pixel_out   <= COLOR_BLANK;
      x_pos       <= '0;
      y_pos       <= '0;
      frame_start <= 1'b0;
    end else begin
      h_sync      <= run && hs_c;
      v_sync      <= run && vs_c;
      de          <= run && active;
      pixel_out   <= run ? pix_d : COLOR_BLANK;
      x_pos       <= (run && active) ? h_cnt : 16'd0;
      y_pos       <= (run && active) ? v_cnt : 16'd0;
      frame_start <= run && (h_cnt == 16'd0) && (v_cnt == 16'd0);
    end
  end

endmodule

// File: tb/tb_synthetic_video_source.sv
// Self-checking bench for synthetic_video_source, built with a reduced frame geometry so
// many frames fit in a short run. The reference model generates each whole frame from the
// raster rules and tracks the object position frame by frame.
module tb_synthetic_video_source;

  localparam int HA = 66, HF = 2, HS = 4, HB = 4;
  localparam int VA = 36, VF = 2, VS = 2, VB = 2;
  localparam int OBJ = 32;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk, rst, enable;
  logic [3:0]  obj_step;
  logic        h_sync, v_sync, de, frame_start;
  logic [23:0] pixel_out;
  logic [15:0] x_pos, y_pos;

  int n_cmp, n_bad;
  int mx, my;
  bit mdx, mdy;
  logic [23:0] cap_64_10, cap_65_10, cap_0_0;

  synthetic_video_source #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .OBJ_SIZE (OBJ)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .obj_step    (obj_step),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .de          (de),
    .pixel_out   (pixel_out),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [59:0] outs();
    return {h_sync, v_sync, de, frame_start, x_pos, y_pos, pixel_out};
  endfunction

  // One frame of bounce motion per axis, straight from the movement rules.
  task automatic model_advance(input int step);
    if (mdx) begin
      if (mx + step > HA - OBJ) begin mx = HA - OBJ; mdx = 0; end
      else mx = mx + step;
    end else begin
      if (step > mx) begin mx = 0; mdx = 1; end
      else mx = mx - step;
    end
    if (mdy) begin
      if (my + step > VA - OBJ) begin my = VA - OBJ; mdy = 0; end
      else my = my + step;
    end else begin
      if (step > my) begin my = 0; mdy = 1; end
      else my = my - step;
    end
  endtask

  // Waits for frame_start, then checks every cycle of the frame against the raster model.
  // enable is dropped/raised at the given (line, pixel) sample points (-1 for never).
  task automatic check_frame(input int drop_v, input int drop_h, input int rise_v,
                             input int rise_h, input logic [3:0] step, output int gap);
    int errs, white, minx, miny, fh, fv;
    logic [59:0] got, want, fgot, fwant;
    logic e_de, e_hs, e_vs, e_fs;
    logic [23:0] e_pix;
    gap = 0;
    while (frame_start !== 1'b1 && gap < 2 * HT * VT) begin
      tick();
      gap++;
    end
    n_cmp++;
    if (frame_start !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_start_wait: got no pulse in %0d cycles, want one", gap);
      return;
    end
    obj_step = step;
    errs = 0; white = 0; minx = HA; miny = VA; fh = 0; fv = 0; fgot = '0; fwant = '0;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        e_de = (h < HA) && (v < VA);
        e_hs = (h >= HA + HF) && (h < HA + HF + HS);
        e_vs = (v >= VA + VF) && (v < VA + VF + VS);
        e_fs = (h == 0) && (v == 0);
        if (!e_de) e_pix = 24'h000000;
        else if (h >= mx && h < mx + OBJ && v >= my && v < my + OBJ) e_pix = 24'hFFFFFF;
        else begin
          e_pix = 24'h202020;
`ifdef SVS_GRID_EN
          if (h % 64 == 0 || v % 64 == 0) e_pix = 24'h303030;
`endif
        end
        want = {e_hs, e_vs, e_de, e_fs, e_de ? 16'(h) : 16'd0, e_de ? 16'(v) : 16'd0, e_pix};
        got  = outs();
        if (got !== want) begin
          if (errs == 0) begin fh = h; fv = v; fgot = got; fwant = want; end
          errs++;
        end
        if (de === 1'b1 && pixel_out === 24'hFFFFFF) begin
          white++;
          if (int'(x_pos) < minx) minx = int'(x_pos);
          if (int'(y_pos) < miny) miny = int'(y_pos);
        end
        if (h == 64 && v == 10) cap_64_10 = pixel_out;
        if (h == 65 && v == 10) cap_65_10 = pixel_out;
        if (h == 0 && v == 0) cap_0_0 = pixel_out;
        if (v == drop_v && h == drop_h) enable = 1'b0;
        if (v == rise_v && h == rise_h) enable = 1'b1;
        tick();
      end
    end
    n_cmp++;
    if (errs !== 0)
      $display("FAIL frame_stream: %0d bad cycles, first at h=%0d v=%0d got %h want %h",
               errs, fh, fv, fgot, fwant);
    if (errs !== 0) n_bad++;
    n_cmp++;
    if (white !== OBJ * OBJ) begin
      n_bad++;
      $display("FAIL obj_area: got %0d white pixels want %0d", white, OBJ * OBJ);
    end
    n_cmp++;
    if (minx !== mx || miny !== my) begin
      n_bad++;
      $display("FAIL obj_pos: got (%0d,%0d) want (%0d,%0d)", minx, miny, mx, my);
    end
    model_advance(int'(step));
  endtask

  task automatic check_idle(input int n, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (outs() !== 60'd0) bad++;
      tick();
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL %s: got %0d non-zero output cycles want 0", name, bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b1;
    obj_step = 4'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (outs() !== 60'd0) begin
        n_bad++;
        $display("FAIL reset_outputs: cycle %0d got %h want 0", i, outs());
      end
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({de, frame_start} !== 2'b00) begin
      n_bad++;
      $display("FAIL start_latency_early: got de/fs %b want 00", {de, frame_start});
    end
    tick();
    n_cmp++;
    if ({de, frame_start} !== 2'b11) begin
      n_bad++;
      $display("FAIL start_latency: got de/fs %b want 11", {de, frame_start});
    end
  endtask

  task automatic test_object_placement();
    int gap;
    check_frame(-1, -1, -1, -1, 4'd4, gap);
    n_cmp++;
    if (gap !== 0) begin
      n_bad++;
      $display("FAIL first_frame_gap: got %0d want 0", gap);
    end
    check_frame(-1, -1, -1, -1, 4'd4, gap);
  endtask

  task automatic test_line_frame_timing();
    int n, hs_rises, r1, r2, hs_w, de_rises, de_run, de_tot, vs_tot, fs_cnt;
    bit hs_done, de_done;
    logic p_hs, p_de;
    n = 0;
    while (frame_start !== 1'b1 && n < 2 * HT * VT) begin tick(); n++; end
    obj_step = 4'd0;
    hs_rises = 0; r1 = 0; r2 = 0; hs_w = 0; de_rises = 0; de_run = 0; de_tot = 0;
    vs_tot = 0; fs_cnt = 0; hs_done = 0; de_done = 0; p_hs = 1'b0; p_de = 1'b0;
    for (int i = 0; i < HT * VT; i++) begin
      if (h_sync && !p_hs) begin
        hs_rises++;
        if (hs_rises == 1) r1 = i;
        if (hs_rises == 2) r2 = i;
      end
      if (h_sync) begin if (!hs_done) hs_w++; end
      else if (hs_w > 0) hs_done = 1;
      if (de && !p_de) de_rises++;
      if (de) begin de_tot++; if (!de_done) de_run++; end
      else if (de_run > 0) de_done = 1;
      if (v_sync) vs_tot++;
      if (frame_start) fs_cnt++;
      p_hs = h_sync;
      p_de = de;
      tick();
    end
    n_cmp++;
    if (r2 - r1 !== HT) begin n_bad++; $display("FAIL hsync_period: got %0d want %0d", r2 - r1, HT); end
    n_cmp++;
    if (hs_w !== HS) begin n_bad++; $display("FAIL hsync_width: got %0d want %0d", hs_w, HS); end
    n_cmp++;
    if (de_run !== HA) begin n_bad++; $display("FAIL de_per_line: got %0d want %0d", de_run, HA); end
    n_cmp++;
    if (de_rises !== VA) begin n_bad++; $display("FAIL active_lines: got %0d want %0d", de_rises, VA); end
    n_cmp++;
    if (de_tot !== HA * VA) begin n_bad++; $display("FAIL de_total: got %0d want %0d", de_tot, HA * VA); end
    n_cmp++;
    if (vs_tot !== VS * HT) begin n_bad++; $display("FAIL vsync_clocks: got %0d want %0d", vs_tot, VS * HT); end
    n_cmp++;
    if (hs_rises !== VT) begin n_bad++; $display("FAIL lines_per_frame: got %0d want %0d", hs_rises, VT); end
    n_cmp++;
    if (fs_cnt !== 1 || frame_start !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_length: got %0d pulses, next start %b want 1 and 1", fs_cnt, frame_start);
    end
    model_advance(0);
  endtask

  task automatic test_bounce();
    int gap;
    for (int f = 0; f < 4; f++) check_frame(-1, -1, -1, -1, 4'd15, gap);
  endtask

  task automatic test_random_motion();
    int gap;
    for (int f = 0; f < 2; f++) check_frame(-1, -1, -1, -1, 4'($urandom_range(0, 15)), gap);
  endtask

  task automatic test_stop_restart();
    int gap;
    check_frame(VA / 2, 0, -1, -1, 4'($urandom_range(1, 15)), gap);
    check_idle(10, "stop_idle");
    enable = 1'b1;
    check_frame(-1, -1, -1, -1, 4'd3, gap);
    n_cmp++;
    if (gap !== 2) begin n_bad++; $display("FAIL restart_latency: got %0d want 2", gap); end
  endtask

  task automatic test_enable_edges();
    int gap;
    check_frame(5, 0, 10, 0, 4'd7, gap);
    check_frame(VT - 1, HT - 2, -1, -1, 4'd9, gap);
    n_cmp++;
    if (gap !== 0) begin n_bad++; $display("FAIL stop_pend_resume_gap: got %0d want 0", gap); end
    check_idle(5, "frame_end_stop");
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    int gap, n;
    n = 0;
    while (frame_start !== 1'b1 && n < 2 * HT * VT) begin tick(); n++; end
    for (int i = 0; i < 5 * HT + 10; i++) tick();
    n_cmp++;
    if (de !== 1'b1) begin n_bad++; $display("FAIL pre_reset_de: got %b want 1", de); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 60'd0) begin n_bad++; $display("FAIL async_clear: got %h want 0", outs()); end
    tick();
    tick();
    rst = 1'b1;
    mx = 0; my = 0; mdx = 1; mdy = 1;
    check_frame(-1, -1, -1, -1, 4'd0, gap);
    n_cmp++;
    if (gap !== 2) begin n_bad++; $display("FAIL reset_restart_latency: got %0d want 2", gap); end
  endtask

  task automatic test_grid();
    logic [23:0] exp_64;
`ifdef SVS_GRID_EN
    exp_64 = 24'h303030;
`else
    exp_64 = 24'h202020;
`endif
    n_cmp++;
    if (cap_64_10 !== exp_64) begin n_bad++; $display("FAIL pix_64_10: got %h want %h", cap_64_10, exp_64); end
    n_cmp++;
    if (cap_65_10 !== 24'h202020) begin n_bad++; $display("FAIL pix_65_10: got %h want 202020", cap_65_10); end
    n_cmp++;
    if (cap_0_0 !== 24'hFFFFFF) begin n_bad++; $display("FAIL pix_0_0: got %h want ffffff", cap_0_0); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    mx = 0; my = 0; mdx = 1; mdy = 1;
    cap_64_10 = '0; cap_65_10 = '0; cap_0_0 = '0;
    rst = 1'b0; enable = 1'b0; obj_step = 4'd0;
    test_reset();
    test_object_placement();
    test_line_frame_timing();
    test_bounce();
    test_random_motion();
    test_stop_restart();
    test_enable_edges();
    test_async_reset();
    test_grid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
